bus_source_arbiter: RTL and testbench

Round-robin arbiter that shares the CPU's 32-bit, 8-input source multiplexer (inputs a..h, selects s2/s1/s0) between eight requesters. It grants one requester at a time, drives the mux select lines for the granted source, and marks the bus valid while the grant is held. The grant is released on requester completion, on request withdrawal, or on a hold-time timeout. It sits in the datapath control, directly in front of the 8:1 mux select inputs.

---
 rtl/bus_source_arbiter_if.sv | 13 +
 rtl/bus_source_arbiter.sv | 58 +++++
 tb/tb_bus_source_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bus_source_arbiter_if.sv
// bus_source_arbiter_if: request/release strobes in, grant and 8:1 mux selects out
interface bus_source_arbiter_if;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic s2;
  logic s1;
  logic s0;
  logic bus_valid;
  logic timeout_err;
  modport master (input req, done, output gnt, s2, s1, s0, bus_valid, timeout_err);
  modport slave (output req, done, input gnt, s2, s1, s0, bus_valid, timeout_err);
endinterface

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: round-robin owner of the 32-bit 8:1 source mux selects
module bus_source_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input logic clk,
  input logic reset,
  bus_source_arbiter_if.master bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [2:0] ptr;
  logic [2:0] pick;
  logic [2:0] sel;
  logic at_limit;
  logic release_now;
  // ptr doubles as the granted index while in GRANT
  assign at_limit = hold_cnt == 8'(MAX_HOLD - 1);
  assign release_now = bus.done[ptr] || !bus.req[ptr] || at_limit;
  assign {bus.s2, bus.s1, bus.s0} = sel;
  // scanning from farthest to nearest leaves the first requester after ptr
  always_comb begin
    pick = ptr;
    for (int k = 8; k >= 1; k--)
      if (bus.req[ptr + 3'(k)]) pick = ptr + 3'(k);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.gnt <= 8'h00;
      sel <= 3'd0;
      bus.bus_valid <= 1'b0;
      bus.timeout_err <= 1'b0;
      hold_cnt <= 8'd0;
      ptr <= 3'd7;
    end else begin
      bus.timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (|bus.req) begin
          state <= GRANT;
          bus.gnt <= 8'b1 << pick;
          sel <= 3'd7 - pick;
          bus.bus_valid <= 1'b1;
          hold_cnt <= 8'd0;
          ptr <= pick;
        end
      end else if (release_now) begin
        state <= IDLE;
        bus.gnt <= 8'h00;
        bus.bus_valid <= 1'b0;
        bus.timeout_err <= at_limit && !bus.done[ptr] && bus.req[ptr];
      end else begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter: random and directed stimulus against a behavioural arbiter model
module tb_bus_source_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int m_owner;
  int m_last;
  int m_held;
  logic [2:0] m_sel;
  logic m_terr;
  bus_source_arbiter_if bus ();
  bus_source_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int winner(input logic [7:0] r, input int last);
    for (int o = 1; o <= 8; o++)
      if (r[(last + o) % 8]) return (last + o) % 8;
    return -1;
  endfunction
  // model: owner index (-1 idle), last winner, cycles the current grant has been held
  always @(posedge clk) begin
    if (reset) begin
      m_owner <= -1;
      m_last <= 7;
      m_held <= 0;
      m_sel <= 3'd0;
      m_terr <= 1'b0;
    end else if (m_owner < 0) begin
      m_terr <= 1'b0;
      if (bus.req != 8'h00) begin
        m_owner <= winner(bus.req, m_last);
        m_last <= winner(bus.req, m_last);
        m_sel <= 3'(7 - winner(bus.req, m_last));
        m_held <= 1;
      end
    end else if (bus.done[m_owner] || !bus.req[m_owner] || m_held == MH) begin
      m_owner <= -1;
      m_terr <= m_held == MH && !bus.done[m_owner] && bus.req[m_owner];
    end else begin
      m_held <= m_held + 1;
      m_terr <= 1'b0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 32'(bus.gnt), m_owner < 0 ? 32'd0 : 32'd1 << m_owner);
      chk("sel", 32'({bus.s2, bus.s1, bus.s0}), 32'(m_sel));
      chk("bus_valid", 32'(bus.bus_valid), 32'(m_owner >= 0));
      chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    end
  end
  initial begin
    reset = 1'b1;
    bus.req = 8'h00;
    bus.done = 8'h00;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'({bus.s2, bus.s1, bus.s0}), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 8'h01;
    @(negedge clk);
    chk("single_gnt", 32'(bus.gnt), 32'h01);
    chk("single_sel", 32'({bus.s2, bus.s1, bus.s0}), 32'h7);
    chk("single_valid", 32'(bus.bus_valid), 32'h1);
    bus.done = 8'h01;
    @(negedge clk);
    chk("single_rel", 32'(bus.gnt), 32'h0);
    chk("single_sel_hold", 32'({bus.s2, bus.s1, bus.s0}), 32'h7);
    bus.done = 8'h00;
    bus.req = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.req = 8'b1 << i;
      @(negedge clk);
      chk("sweep_sel", 32'({bus.s2, bus.s1, bus.s0}), 32'(7 - i));
      bus.done = 8'b1 << i;
      @(negedge clk);
      bus.done = 8'h00;
      bus.req = 8'h00;
      @(negedge clk);
    end
    bus.req = 8'hFF;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      chk("rr_order", 32'(bus.gnt), 32'd1 << (k % 8));
      bus.done = bus.gnt;
      @(negedge clk);
      chk("rr_idle", 32'(bus.bus_valid), 32'h0);
      bus.done = 8'h00;
      @(negedge clk);
    end
    bus.req = 8'h00;
    @(negedge clk);
    @(negedge clk);
    bus.req = 8'h08;
    for (int k = 0; k < MH; k++) begin
      @(negedge clk);
      chk("to_held", 32'(bus.gnt), 32'h08);
    end
    @(negedge clk);
    chk("to_rel", 32'(bus.gnt), 32'h0);
    chk("to_err", 32'(bus.timeout_err), 32'h1);
    @(negedge clk);
    chk("to_regrant", 32'(bus.gnt), 32'h08);
    chk("to_err_clr", 32'(bus.timeout_err), 32'h0);
    repeat (MH - 1) @(negedge clk);
    bus.done = 8'h08;
    @(negedge clk);
    chk("to_done_rel", 32'(bus.gnt), 32'h0);
    chk("to_done_noerr", 32'(bus.timeout_err), 32'h0);
    bus.done = 8'h00;
    bus.req = 8'h00;
    @(negedge clk);
    bus.req = 8'h04;
    @(negedge clk);
    bus.done = 8'hFB;
    @(negedge clk);
    chk("other_done", 32'(bus.gnt), 32'h04);
    bus.done = 8'h00;
    bus.req = 8'h00;
    @(negedge clk);
    chk("req_drop", 32'(bus.gnt), 32'h0);
    bus.req = 8'h20;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'h20);
    reset = 1'b1;
    bus.req = 8'h21;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
    chk("mid_rst_sel", 32'({bus.s2, bus.s1, bus.s0}), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_win", 32'(bus.gnt), 32'h01);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
      bus.done = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00;
      reset = $urandom_range(0, 299) == 0;
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
